// File: rtl/r_mem_loader_pkg.sv
// Shared definitions for the R memory loader.
//   WORD_W  - serial word width in bits
//   DEPTH   - words per load (R memory depth)
//   ADDR_W  - memory address width, DEPTH == 2**ADDR_W
//   CNT_W   - width of the received-bit counter
//   state_t - loader FSM state encoding
package r_mem_loader_pkg;

    localparam int WORD_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/r_mem_loader_serial_shift_in.sv
// Serial-to-parallel shifter with received-bit counter.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - zero the bit counter (restart or word completed)
//   load_msb   - take sdata as the first (MSB) bit of a new word, count = 1
//   shift      - append sdata below the bits already held, count + 1
//   sdata      - serial input bit
//   word       - assembled word: held bits with the current sdata as LSB
//   last_bit   - the current sdata is the LSB of the word being received
// Priority when several controls are high: clear, then load_msb, then shift.
module r_mem_loader_serial_shift_in
    import r_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_msb,
    input  logic              shift,
    input  logic              sdata,
    output logic [WORD_W-1:0] word,
    output logic              last_bit
);

    // Only WORD_W-1 bits are ever stored: the LSB is used straight from
    // sdata on the cycle it arrives, so the word is ready at that edge.
    logic [WORD_W-2:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
        end else if (load_msb) begin
            shift_q <= {{(WORD_W-2){1'b0}}, sdata};
            cnt_q   <= CNT_W'(1);
        end else if (shift) begin
            shift_q <= {shift_q[WORD_W-3:0], sdata};
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign word     = {shift_q, sdata};
    assign last_bit = (cnt_q == CNT_W'(WORD_W-1));

endmodule

// File: rtl/r_mem_loader.sv
// Fills the 16-entry R memory from a framed, MSB-first serial stream.
// Ports:
//   Sclk          - system clock, all state changes on posedge
//   Reset_n       - asynchronous active-low reset
//   Start         - synchronous restart: address 0, flags cleared, IDLE
//   Frame         - high on the MSB cycle of each word
//   Sdata         - serial data, one bit per Sclk
//   write_enable  - one-cycle write strobe to the memory
//   Frame_wr      - memory Frame pin, identical to write_enable
//   Write_Address - address of the word being written (held between writes)
//   data_in       - assembled word (held between writes)
//   Load_done     - high from the cycle after the last write until Start/reset
//   Sync_err      - sticky: a Frame arrived while a word was partly received
//   state_dbg     - current FSM state, for observation only
// Write port handshake: write_enable/Frame_wr form a push-only strobe with no
// back-pressure. While the strobe is high, Write_Address and data_in are valid
// and the memory must take them (it latches on the following negedge); each
// strobe lasts exactly one cycle and is never repeated for the same word.
module r_mem_loader
    import r_mem_loader_pkg::*;
(
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Frame,
    input  logic              Sdata,
    output logic              write_enable,
    output logic              Frame_wr,
    output logic [ADDR_W-1:0] Write_Address,
    output logic [WORD_W-1:0] data_in,
    output logic              Load_done,
    output logic              Sync_err,
    output state_t            state_dbg
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] word;
    logic              last_bit;
    logic              load_msb;
    logic              shift_en;
    logic              clear;

    // A Frame outside DONE always starts a new word: from IDLE it is a
    // normal word start, in RECV it is a resync that drops the partial word.
    assign load_msb = !Start && Frame && (state != DONE);
    assign shift_en = !Start && !Frame && (state == RECV) && !last_bit;
    assign clear    = Start || (!Frame && (state == RECV) && last_bit);

    r_mem_loader_serial_shift_in u_shift (
        .clk      (Sclk),
        .rst_n    (Reset_n),
        .clear    (clear),
        .load_msb (load_msb),
        .shift    (shift_en),
        .sdata    (Sdata),
        .word     (word),
        .last_bit (last_bit)
    );

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            write_enable  <= 1'b0;
            Write_Address <= '0;
            data_in       <= '0;
            Load_done     <= 1'b0;
            Sync_err      <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (Start) begin
                state     <= IDLE;
                addr_q    <= '0;
                Load_done <= 1'b0;
                Sync_err  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Frame) state <= RECV;
                    end
                    RECV: begin
                        if (Frame) begin
                            Sync_err <= 1'b1;
                        end else if (last_bit) begin
                            write_enable  <= 1'b1;
                            data_in       <= word;
                            Write_Address <= addr_q;
                            // The address stops at DEPTH-1; DONE blocks
                            // anything beyond the last entry.
                            if (addr_q == ADDR_W'(DEPTH-1)) begin
                                state  <= DONE;
                            end else begin
                                addr_q <= addr_q + ADDR_W'(1);
                                state  <= IDLE;
                            end
                        end
                    end
                    DONE: begin
                        // Set one cycle after entry, i.e. after the last strobe.
                        Load_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign Frame_wr  = write_enable;
    assign state_dbg = state;

endmodule
